// File: rtl/bit_unstuffer_param.sv
// USB-style bit unstuffer with optional NRZI decode, stuff-violation detection,
// per-packet removed-bit count, gap tolerance and fully registered outputs.
module bit_unstuffer_param #(
    parameter int RUN_LEN     = 6,
    parameter bit NRZI_DECODE = 1'b0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_done,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_done,
    output logic             stuff_err,
    output logic             pkt_err,
    output logic [CNT_W-1:0] stuff_cnt
);

    localparam int RW = $clog2(RUN_LEN + 1);
    localparam logic [RW-1:0] RUN_LEN_L = RW'(RUN_LEN);

    typedef enum logic {
        RUN   = 1'b0,
        STUFF = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [RW-1:0]    run_cnt, run_nxt, run_inc;
    logic             prev_level, prev_nxt;
    logic             sticky, sticky_nxt, sticky_upd;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_upd;

    logic             d;
    logic             stuff_slot;
    logic             out_bit_nxt, out_valid_nxt, out_done_nxt;
    logic             stuff_err_nxt, pkt_err_nxt;
    logic [CNT_W-1:0] stuff_cnt_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A transition on the line decodes to 0, no transition to 1.
    assign d          = NRZI_DECODE ? ~(in_bit ^ prev_level) : in_bit;
    assign run_inc    = run_cnt + RW'(1);
    assign stuff_slot = in_valid && (state == STUFF);
    assign sticky_upd = sticky | (stuff_slot & d);
    assign cnt_upd    = stuff_slot ? sat_inc(cnt) : cnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            run_cnt    <= '0;
            prev_level <= 1'b1;
            sticky     <= 1'b0;
            cnt        <= '0;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            out_done   <= 1'b0;
            stuff_err  <= 1'b0;
            pkt_err    <= 1'b0;
            stuff_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            run_cnt    <= run_nxt;
            prev_level <= prev_nxt;
            sticky     <= sticky_nxt;
            cnt        <= cnt_nxt;
            out_bit    <= out_bit_nxt;
            out_valid  <= out_valid_nxt;
            out_done   <= out_done_nxt;
            stuff_err  <= stuff_err_nxt;
            pkt_err    <= pkt_err_nxt;
            stuff_cnt  <= stuff_cnt_nxt;
        end
    end

    // Next-state logic; end-of-packet clears after the same-cycle bit is applied
    always_comb begin
        state_nxt  = state;
        run_nxt    = run_cnt;
        prev_nxt   = prev_level;
        sticky_nxt = sticky_upd;
        cnt_nxt    = cnt_upd;
        if (in_valid) begin
            prev_nxt = in_bit;
            if (state == RUN) begin
                if (d) begin
                    if (run_inc == RUN_LEN_L) begin
                        state_nxt = STUFF;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run_inc;
                    end
                end else begin
                    run_nxt = '0;
                end
            end else begin
                state_nxt = RUN;
                run_nxt   = '0;
            end
        end
        if (in_done) begin
            state_nxt  = RUN;
            run_nxt    = '0;
            prev_nxt   = 1'b1;
            sticky_nxt = 1'b0;
            cnt_nxt    = '0;
        end
    end

    // Output logic
    always_comb begin
        out_valid_nxt = in_valid && (state == RUN);
        out_bit_nxt   = out_valid_nxt & d;
        stuff_err_nxt = stuff_slot & d;
        out_done_nxt  = in_done;
        pkt_err_nxt   = in_done ? sticky_upd : pkt_err;
        stuff_cnt_nxt = in_done ? cnt_upd : stuff_cnt;
    end

endmodule

// File: tb/tb_bit_unstuffer_param.sv
// Directed, table-driven bench for bit_unstuffer_param: plain data, NRZI and
// saturating-count variants share one stimulus bus.
module tb_bit_unstuffer_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_bit = 1'b0, in_valid = 1'b0, in_done = 1'b0;

    logic ob0, ov0, od0, se0, pe0;
    logic ob1, ov1, od1, se1, pe1;
    logic ob2, ov2, od2, se2, pe2;
    logic [7:0] sc0, sc1;
    logic [1:0] sc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_unstuffer_param #(.RUN_LEN(6), .NRZI_DECODE(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_done(in_done),
        .out_bit(ob0), .out_valid(ov0), .out_done(od0), .stuff_err(se0),
        .pkt_err(pe0), .stuff_cnt(sc0));

    bit_unstuffer_param #(.RUN_LEN(6), .NRZI_DECODE(1'b1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_done(in_done),
        .out_bit(ob1), .out_valid(ov1), .out_done(od1), .stuff_err(se1),
        .pkt_err(pe1), .stuff_cnt(sc1));

    bit_unstuffer_param #(.RUN_LEN(6), .NRZI_DECODE(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_done(in_done),
        .out_bit(ob2), .out_valid(ov2), .out_done(od2), .stuff_err(se2),
        .pkt_err(pe2), .stuff_cnt(sc2));

    typedef struct {
        string      nm;
        logic       v, b, d;
        logic       ov, ob, dn, se, pe;
        logic [7:0] cnt;
    } vec_t;

    vec_t q[$];

    task automatic add(input string nm, input logic v, input logic b, input logic d,
                       input logic ov, input logic ob, input logic dn, input logic se,
                       input logic pe, input int cnt);
        vec_t t;
        t.nm = nm; t.v = v; t.b = b; t.d = d;
        t.ov = ov; t.ob = ob; t.dn = dn; t.se = se; t.pe = pe; t.cnt = 8'(cnt);
        q.push_back(t);
    endtask

    task automatic add_ones(input string nm, input int n);
        for (int i = 0; i < n; i++) add(nm, 1, 1, 0, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic sample(input int sel, output logic ov, output logic ob, output logic dn,
                          output logic se, output logic pe, output logic [7:0] cnt);
        case (sel)
            1:       begin ov = ov1; ob = ob1; dn = od1; se = se1; pe = pe1; cnt = sc1; end
            2:       begin ov = ov2; ob = ob2; dn = od2; se = se2; pe = pe2; cnt = {6'd0, sc2}; end
            default: begin ov = ov0; ob = ob0; dn = od0; se = se0; pe = pe0; cnt = sc0; end
        endcase
    endtask

    task automatic run_queue(input int sel);
        logic ov, ob, dn, se, pe, ok;
        logic [7:0] cnt;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            in_valid = q[i].v; in_bit = q[i].b; in_done = q[i].d;
            @(posedge clk);
            #1;
            sample(sel, ov, ob, dn, se, pe, cnt);
            ok = (ov === q[i].ov) && (dn === q[i].dn) && (se === q[i].se) &&
                 (!q[i].ov || ob === q[i].ob) &&
                 (!q[i].dn || (pe === q[i].pe && cnt === q[i].cnt));
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s[%0d] dut%0d got ov=%b ob=%b done=%b serr=%b perr=%b cnt=%0d want ov=%b ob=%b done=%b serr=%b perr=%b cnt=%0d",
                         q[i].nm, i, sel, ov, ob, dn, se, pe, cnt,
                         q[i].ov, q[i].ob, q[i].dn, q[i].se, q[i].pe, q[i].cnt);
            end
        end
        @(negedge clk);
        in_valid = 0; in_bit = 0; in_done = 0;
        q.delete();
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    task automatic check_zero(input string nm);
        logic [7:0] agg;
        agg = {ob0, ov0, od0, se0, pe0, 3'b000} | sc0;
        checks++;
        if (agg !== 8'd0 || {ov1, od1, ov2, od2} !== 4'd0) begin
            errors++;
            $display("FAIL %s outputs not cleared: dut0 ob=%b ov=%b done=%b serr=%b perr=%b cnt=%0d, want all 0",
                     nm, ob0, ov0, od0, se0, pe0, sc0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check_zero("reset_state");
        @(negedge clk) rst = 0;

        // Plain stuffing: six ones, stuff 0 removed, then 1 0
        add_ones("t1_ones", 6);
        add("t1_stuff", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t1_b1",    1, 1, 0, 1, 1, 0, 0, 0, 0);
        add("t1_b0",    1, 0, 0, 1, 0, 0, 0, 0, 0);
        add("t1_done",  0, 0, 1, 0, 0, 1, 0, 0, 1);
        // Violation: seventh one sits in the stuff slot
        add_ones("t2_ones", 6);
        add("t2_viol",  1, 1, 0, 0, 0, 0, 1, 0, 0);
        add("t2_done",  0, 0, 1, 0, 0, 1, 0, 1, 1);
        // Run survives an in_valid gap
        add_ones("t3_pre", 3);
        for (int i = 0; i < 5; i++) add("t3_gap", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_ones("t3_post", 3);
        add("t3_stuff", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t3_b1",    1, 1, 0, 1, 1, 0, 0, 0, 0);
        add("t3_done",  0, 0, 1, 0, 0, 1, 0, 0, 1);
        // in_done with the sixth one; next packet starts fresh
        add_ones("t5_ones", 5);
        add("t5_done6", 1, 1, 1, 1, 1, 1, 0, 0, 0);
        add_ones("t5_next", 6);
        add("t5_stuff", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t5_done",  0, 0, 1, 0, 0, 1, 0, 0, 1);
        // in_done while a stuff bit is pending: abandoned, no error
        add_ones("ab_ones", 6);
        add("ab_done",  0, 0, 1, 0, 0, 1, 0, 0, 0);
        // RUN_LEN-1 ones then 0 is ordinary data
        add_ones("r5_ones", 5);
        add("r5_zero",  1, 0, 0, 1, 0, 0, 0, 0, 0);
        add("r5_b1",    1, 1, 0, 1, 1, 0, 0, 0, 0);
        add("r5_done",  0, 0, 1, 0, 0, 1, 0, 0, 0);
        run_queue(0);

        // NRZI decode from idle level 1: line 1,0,1,1,0 -> 1,0,0,1,0
        pulse_rst();
        add("nrzi_l1", 1, 1, 0, 1, 1, 0, 0, 0, 0);
        add("nrzi_l0", 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add("nrzi_l1", 1, 1, 0, 1, 0, 0, 0, 0, 0);
        add("nrzi_l1", 1, 1, 0, 1, 1, 0, 0, 0, 0);
        add("nrzi_l0", 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add("nrzi_done", 0, 0, 1, 0, 0, 1, 0, 0, 0);
        run_queue(1);

        // Two-bit count saturates at 3 after five stuffed runs
        pulse_rst();
        for (int r = 0; r < 5; r++) begin
            add_ones("sat_ones", 6);
            add("sat_stuff", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        add("sat_done", 0, 0, 1, 0, 0, 1, 0, 0, 3);
        run_queue(2);

        // Asynchronous reset mid-run clears outputs and the run counter
        pulse_rst();
        add_ones("mr_pre", 3);
        run_queue(0);
        add_ones("mr_pre2", 1);
        q[0].v = 1;
        @(negedge clk);
        in_valid = 1; in_bit = 1;
        @(posedge clk);
        #1;
        checks++;
        if (ov0 !== 1'b1) begin
            errors++;
            $display("FAIL mr_before_rst got ov=%b want 1", ov0);
        end
        q.delete();
        #2 rst = 1;
        #1 check_zero("mr_async_rst");
        @(negedge clk);
        rst = 0; in_valid = 0; in_bit = 0;
        add_ones("mr_post", 3);
        add("mr_zero", 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add("mr_done", 0, 0, 1, 0, 0, 1, 0, 0, 0);
        run_queue(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
